// File: rtl/instr_fetch_arbiter.sv
// Two-port arbiter in front of the single-port instruction ROM.
// Grants one request per cycle, with an anti-starvation boost for the debug port. Responses come back one cycle later.
module instr_fetch_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    input  logic [ADDR_W-1:0]          req0_addr,
    output logic                       req0_ready,
    output logic                       rsp0_valid,
    output logic [31:0]                rsp0_data,
    output logic                       rsp0_err,
    input  logic                       req1_valid,
    input  logic [ADDR_W-1:0]          req1_addr,
    output logic                       req1_ready,
    output logic                       rsp1_valid,
    output logic [31:0]                rsp1_data,
    output logic                       rsp1_err,
    output logic                       mem_en,
    output logic [$clog2(DEPTH)-1:0]   mem_addr,
    input  logic [31:0]                mem_rdata
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned WA_W    = ADDR_W - 2;
    localparam logic [3:0]  MAX_CNT = 4'(MAX_WAIT);

    typedef enum logic {
        CORE_PRI = 1'b0,
        DBG_PRI  = 1'b1
    } pri_e;

    pri_e              state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              inflight_q, inflight_d;
    logic              owner_q, owner_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] sel_addr;
    logic              acc_err;

    // State, wait counter and in-flight response tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CORE_PRI;
            wait_cnt_q <= '0;
            inflight_q <= 1'b0;
            owner_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            inflight_q <= inflight_d;
            owner_q    <= owner_d;
            err_q      <= err_d;
        end
    end

    // Grant, address check, ROM drive and next-state logic
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        inflight_d = 1'b0;
        owner_d    = 1'b0;
        err_d      = 1'b0;

        // No grants while reset is asserted; a lone request always wins
        if (!rst) begin
            if (state_q == DBG_PRI) begin
                req1_ready = req1_valid;
                req0_ready = req0_valid & ~req1_valid;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid & ~req0_valid;
            end
        end

        sel_addr = req1_ready ? req1_addr : req0_addr;
        acc_err  = (sel_addr[1:0] != 2'b00) || (sel_addr[ADDR_W-1:2] >= WA_W'(DEPTH));

        if (req0_ready || req1_ready) begin
            inflight_d = 1'b1;
            owner_d    = req1_ready;
            err_d      = acc_err;
            if (!acc_err) begin
                mem_en   = 1'b1;
                mem_addr = sel_addr[AW+1:2];
            end
        end

        if (!req1_valid || req1_ready) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        // Boost port 1 as soon as its denied count reaches the limit
        if (state_q == CORE_PRI) begin
            if (wait_cnt_d == MAX_CNT) begin
                state_d = DBG_PRI;
            end
        end else begin
            if (req1_ready) begin
                state_d = CORE_PRI;
            end
        end
    end

    // Response steering: data is forced to zero unless a good response is presented
    always_comb begin
        rsp0_valid = inflight_q & ~owner_q;
        rsp1_valid = inflight_q & owner_q;
        rsp0_err   = rsp0_valid & err_q;
        rsp1_err   = rsp1_valid & err_q;
        rsp0_data  = (rsp0_valid && !err_q) ? mem_rdata : 32'h0;
        rsp1_data  = (rsp1_valid && !err_q) ? mem_rdata : 32'h0;
    end

endmodule
